// File: rtl/ttw_mem_rsp.sv
// Fixed-latency memory responder for the table walker: DEPTH tagged slots over a 16-line backing store.
// Define TTW_MEM_RSP_OOO_EN to return eligible responses lowest-slot-first instead of in acceptance order.
module ttw_mem_rsp #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned MCN_W = 58,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mem_req_i_valid,
    output logic               mem_req_i_ready,
    input  logic [IDX_W-1:0]   mem_req_i_bits_idx,
    input  logic [MCN_W-1:0]   mem_req_i_bits_mcn,
    output logic               mem_res_o_valid,
    input  logic               mem_res_o_ready,
    output logic [IDX_W-1:0]   mem_res_o_bits_idx,
    output logic [511:0]       mem_res_o_bits_data,
    input  logic               ld_i_valid,
    input  logic [3:0]         ld_i_addr,
    input  logic [511:0]       ld_i_data,
    output logic               busy_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LINE_W = 4;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned LINES  = 16;

    logic [DEPTH-1:0]  occ_q;
    logic [IDX_W-1:0]  idx_q  [DEPTH];
    logic [LINE_W-1:0] line_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q  [DEPTH];
    logic [DATA_W-1:0] store_q [LINES];

    logic [DEPTH-1:0]  elig_c;
    logic [PTR_W-1:0]  sel_c;
    logic [PTR_W-1:0]  alloc_c;
    logic              rsp_valid_c;
    logic              acc_c;
    logic              hs_c;

    // Only the low line bits address the store.
    logic unused_mcn;
    assign unused_mcn = ^mem_req_i_bits_mcn[MCN_W-1:LINE_W];

    always_comb begin
        elig_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            elig_c[i] = occ_q[i] && (cnt_q[i] == '0);
        end
    end

`ifdef TTW_MEM_RSP_OOO_EN
    logic             hold_q;
    logic [PTR_W-1:0] hold_sel_q;
    logic             afound;
    logic             efound;
    logic [PTR_W-1:0] pick;

    // Lowest free slot for allocation; lowest eligible slot for response unless one is already presented.
    always_comb begin
        alloc_c = '0;
        pick    = '0;
        afound  = 1'b0;
        efound  = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!occ_q[i] && !afound) begin
                alloc_c = PTR_W'(i);
                afound  = 1'b1;
            end
            if (elig_c[i] && !efound) begin
                pick   = PTR_W'(i);
                efound = 1'b1;
            end
        end
        sel_c       = hold_q ? hold_sel_q : pick;
        rsp_valid_c = |elig_c;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_q     <= 1'b0;
            hold_sel_q <= '0;
        end else begin
            hold_q     <= rsp_valid_c && !mem_res_o_ready;
            hold_sel_q <= sel_c;
        end
    end
`else
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;

    // Slots form a ring: allocate at the tail, respond from the head.
    always_comb begin
        alloc_c     = wr_ptr_q;
        sel_c       = rd_ptr_q;
        rsp_valid_c = elig_c[rd_ptr_q];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (acc_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (hs_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end
`endif

    assign acc_c = mem_req_i_valid && mem_req_i_ready;
    assign hs_c  = rsp_valid_c && mem_res_o_ready;

    // Slot state: allocation, countdown, release on handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            occ_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx_q[i]  <= '0;
                line_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (occ_q[i] && (cnt_q[i] != '0)) begin
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
                if (hs_c && (sel_c == PTR_W'(i))) begin
                    occ_q[i] <= 1'b0;
                end
                if (acc_c && (alloc_c == PTR_W'(i))) begin
                    occ_q[i]  <= 1'b1;
                    idx_q[i]  <= mem_req_i_bits_idx;
                    line_q[i] <= mem_req_i_bits_mcn[LINE_W-1:0];
                    cnt_q[i]  <= CNT_W'(LAT - 1);
                end
            end
        end
    end

    // Backing store is deliberately not reset.
    always_ff @(posedge clock) begin
        if (ld_i_valid) begin
            store_q[ld_i_addr] <= ld_i_data;
        end
    end

    assign mem_req_i_ready     = ~&occ_q;
    assign busy_o              = |occ_q;
    assign mem_res_o_valid     = rsp_valid_c;
    assign mem_res_o_bits_idx  = rsp_valid_c ? idx_q[sel_c] : '0;
    assign mem_res_o_bits_data = store_q[line_q[sel_c]];

endmodule

// File: tb/tb_ttw_mem_rsp.sv
// Randomized and directed bench for ttw_mem_rsp against a queue-based response model.
module tb_ttw_mem_rsp;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned MCN_W = 58;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 8;

    logic               clock = 1'b0;
    logic               reset;
    logic               mem_req_i_valid;
    logic               mem_req_i_ready;
    logic [IDX_W-1:0]   mem_req_i_bits_idx;
    logic [MCN_W-1:0]   mem_req_i_bits_mcn;
    logic               mem_res_o_valid;
    logic               mem_res_o_ready;
    logic [IDX_W-1:0]   mem_res_o_bits_idx;
    logic [511:0]       mem_res_o_bits_data;
    logic               ld_i_valid;
    logic [3:0]         ld_i_addr;
    logic [511:0]       ld_i_data;
    logic               busy_o;

    ttw_mem_rsp #(.IDX_W(IDX_W), .MCN_W(MCN_W), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clock               (clock),
        .reset               (reset),
        .mem_req_i_valid     (mem_req_i_valid),
        .mem_req_i_ready     (mem_req_i_ready),
        .mem_req_i_bits_idx  (mem_req_i_bits_idx),
        .mem_req_i_bits_mcn  (mem_req_i_bits_mcn),
        .mem_res_o_valid     (mem_res_o_valid),
        .mem_res_o_ready     (mem_res_o_ready),
        .mem_res_o_bits_idx  (mem_res_o_bits_idx),
        .mem_res_o_bits_data (mem_res_o_bits_data),
        .ld_i_valid          (ld_i_valid),
        .ld_i_addr           (ld_i_addr),
        .ld_i_data           (ld_i_data),
        .busy_o              (busy_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [3:0]       line;
        int               elig;
    } ent_t;

    ent_t         q[$];
    logic [511:0] mem_m [16];
    int           edge_n = 0;
    int           total  = 0;
    int           bad    = 0;
    logic         held_v = 1'b0;
    int           held_pos = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_valid();
        logic v = 1'b0;
`ifdef TTW_MEM_RSP_OOO_EN
        foreach (q[i]) if (edge_n >= q[i].elig) v = 1'b1;
`else
        if (q.size() > 0) v = (edge_n >= q[0].elig);
`endif
        return v;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock: check outputs against the model, drive inputs, then advance the model at the edge.
    task automatic step(input logic rv, input logic [IDX_W-1:0] ri, input logic [MCN_W-1:0] rm,
                        input logic sr, input logic lv, input logic [3:0] la, input logic [511:0] ldd);
        logic mv;
        logic mr;
        int   sp;
        @(negedge clock);
        mv = model_valid();
        sp = 0;
        mr = (q.size() < DEPTH);
`ifdef TTW_MEM_RSP_OOO_EN
        if (held_v) sp = held_pos;
        else if (mv) begin
            logic got_one = 1'b0;
            foreach (q[i]) if (edge_n >= q[i].elig && !got_one) begin sp = i; got_one = 1'b1; end
            foreach (q[i]) if (edge_n >= q[i].elig && q[i].idx == mem_res_o_bits_idx
                               && mem_m[q[i].line] == mem_res_o_bits_data) sp = i;
        end
`endif
        check("ready", 512'(mem_req_i_ready), 512'(mr));
        check("busy",  512'(busy_o), 512'(q.size() != 0));
        check("valid", 512'(mem_res_o_valid), 512'(mv));
        if (mv) begin
            check("rsp_idx",  512'(mem_res_o_bits_idx), 512'(q[sp].idx));
            check("rsp_data", mem_res_o_bits_data, mem_m[q[sp].line]);
        end
        mem_req_i_valid    = rv;
        mem_req_i_bits_idx = ri;
        mem_req_i_bits_mcn = rm;
        mem_res_o_ready    = sr;
        ld_i_valid         = lv;
        ld_i_addr          = la;
        ld_i_data          = ldd;
        @(posedge clock);
        edge_n++;
        held_v   = mv && !sr;
        held_pos = sp;
        if (mv && sr) q.delete(sp);
        if (rv && mr) q.push_back('{idx: ri, line: rm[3:0], elig: edge_n + int'(LAT) - 1});
        if (lv) mem_m[la] = ldd;
        #1;
    endtask

    task automatic idle(input logic sr);
        step(1'b0, '0, '0, sr, 1'b0, 4'd0, '0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin idle(1'b1); n++; end
        if (q.size() != 0) check("drain_timeout", 512'(busy_o), 512'(1'b0));
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!model_valid() && n < 40) begin idle(1'b0); n++; end
        if (!model_valid()) check("wait_timeout", 512'(mem_res_o_valid), 512'(1'b1));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        mem_req_i_valid = 1'b0;
        mem_res_o_ready = 1'b0;
        ld_i_valid      = 1'b0;
        #1;
        check("rst_ready", 512'(mem_req_i_ready), 512'(1'b1));
        check("rst_valid", 512'(mem_res_o_valid), 512'(1'b0));
        check("rst_idx",   512'(mem_res_o_bits_idx), 512'(0));
        check("rst_busy",  512'(busy_o), 512'(1'b0));
        q.delete();
        held_v = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [511:0] a5;
        logic [511:0] old5;
        logic [511:0] new5;
        reset = 1'b1;
        mem_req_i_valid = 1'b0; mem_req_i_bits_idx = '0; mem_req_i_bits_mcn = '0;
        mem_res_o_ready = 1'b0; ld_i_valid = 1'b0; ld_i_addr = '0; ld_i_data = '0;
        do_reset();

        // Preload every line so random requests return known data.
        for (int i = 0; i < 16; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 4'(i), rnd512());

        // Line 3 = A5 pattern, single request, ready held high.
        for (int i = 0; i < 64; i++) a5[i*8 +: 8] = 8'hA5;
        step(1'b0, '0, '0, 1'b1, 1'b1, 4'd3, a5);
        step(1'b1, 4'd2, 58'h13, 1'b1, 1'b0, 4'd0, '0);
        for (int i = 0; i < int'(LAT) + 2; i++) idle(1'b1);

        // Fill all slots with responses stalled, keep pushing a fifth request.
        for (int i = 0; i < 6; i++) step(1'b1, 4'(i), 58'(i), 1'b0, 1'b0, 4'd0, '0);
        wait_valid();
        step(1'b1, 4'd9, 58'h9, 1'b1, 1'b0, 4'd0, '0);
        step(1'b1, 4'd9, 58'h9, 1'b0, 1'b0, 4'd0, '0);
        drain();

        // Ordering: idx 0..3 consecutive, responses released at cycle 20.
        for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 58'(i + 4), 1'b0, 1'b0, 4'd0, '0);
        for (int i = 4; i < 20; i++) idle(1'b0);
        drain();

        // Same-cycle store write to the responding line returns old data.
        old5 = rnd512();
        new5 = rnd512();
        step(1'b0, '0, '0, 1'b0, 1'b1, 4'd5, old5);
        step(1'b1, 4'd7, 58'h25, 1'b0, 1'b0, 4'd0, '0);
        wait_valid();
        step(1'b0, '0, '0, 1'b1, 1'b1, 4'd5, new5);
        step(1'b1, 4'd8, 58'h5, 1'b0, 1'b0, 4'd0, '0);
        wait_valid();
        drain();

        // Reset with three requests outstanding; nothing may come back afterwards.
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 10), 58'(i), 1'b1, 1'b0, 4'd0, '0);
        do_reset();
        step(1'b1, 4'd12, 58'h1, 1'b0, 1'b0, 4'd0, '0);
        for (int i = 0; i < 15; i++) idle(1'b0);
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60, 4'($urandom), {26'($urandom), 32'($urandom)},
                 $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 10, 4'($urandom), rnd512());
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
